jtbubl_vtimer_gen: RTL and testbench

// Parametrised video timing generator; successor of the fixed-geometry timer in the video top.

---
 rtl/jtbubl_vtimer_gen_pkg.sv | 26 ++
 rtl/jtbubl_vtimer_dly.sv | 34 +++
 rtl/jtbubl_vtimer_gen.sv | 140 ++++++++++++++
 tb/tb_jtbubl_vtimer_gen.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtbubl_vtimer_gen_pkg.sv
// Shared defaults for the video timing generator: the Bubble Bobble
// 384x264 raster geometry, also used by jtbubl_video and the benches.
package jtbubl_vtimer_gen_pkg;

    localparam int DEF_HW       = 9;
    localparam int DEF_H_START  = 0;
    localparam int DEF_H_END    = 383;
    localparam int DEF_HB_START = 255;
    localparam int DEF_HB_END   = 383;
    localparam int DEF_HS_START = 287;
    localparam int DEF_HS_END   = 319;
    localparam int DEF_V_START  = 16;
    localparam int DEF_V_END    = 279;
    localparam int DEF_VB_START = 239;
    localparam int DEF_VB_END   = 279;
    localparam int DEF_VS_START = 255;
    localparam int DEF_VS_END   = 263;
    localparam int DEF_DLY      = 4;

    // A window whose start equals its end is a configuration error; such a
    // signal is frozen at its reset value instead of toggling every pass.
    function automatic bit window_en(input int start_v, input int end_v);
        return start_v != end_v;
    endfunction

endpackage

// File: rtl/jtbubl_vtimer_dly.sv
// Generic W-bit shift pipe advancing only on cen. DLY=0 is a plain wire.
module jtbubl_vtimer_dly #(
    parameter int W   = 2,
    parameter int DLY = 4
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         cen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    generate
        if (DLY == 0) begin : g_pass
            assign q = d;
        end else begin : g_pipe
            logic [W-1:0] pipe [DLY];

            // Shift one stage per enabled clock; reset clears every stage so
            // no stale value leaks out after a mid-frame reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DLY; i++) pipe[i] <= '0;
                end else if (cen) begin
                    pipe[0] <= d;
                    for (int i = 1; i < DLY; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[DLY-1];
        end
    endgenerate

endmodule

// File: rtl/jtbubl_vtimer_gen.sv
// Parametrised video timing generator: H/V counters on pxl_cen, blanking,
// sync, render lookahead with optional vertical flip, frame parity and a
// delayed copy of the blanking signals for colmix alignment.
module jtbubl_vtimer_gen
    import jtbubl_vtimer_gen_pkg::*;
#(
    parameter int HW       = DEF_HW,
    parameter int H_START  = DEF_H_START,
    parameter int H_END    = DEF_H_END,
    parameter int HB_START = DEF_HB_START,
    parameter int HB_END   = DEF_HB_END,
    parameter int HS_START = DEF_HS_START,
    parameter int HS_END   = DEF_HS_END,
    parameter int V_START  = DEF_V_START,
    parameter int V_END    = DEF_V_END,
    parameter int VB_START = DEF_VB_START,
    parameter int VB_END   = DEF_VB_END,
    parameter int VS_START = DEF_VS_START,
    parameter int VS_END   = DEF_VS_END,
    parameter int DLY      = DEF_DLY
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          flip,
    output logic [HW-1:0] H,
    output logic [HW-1:0] vdump,
    output logic [HW-1:0] vrender,
    output logic [HW-1:0] vrender1,
    output logic          Hinit,
    output logic          Vinit,
    output logic          LHBL,
    output logic          LVBL,
    output logic          LHBL_dly,
    output logic          LVBL_dly,
    output logic          HS,
    output logic          VS,
    output logic          frame
);

    localparam logic [HW-1:0] H_S   = HW'(H_START);
    localparam logic [HW-1:0] H_E   = HW'(H_END);
    localparam logic [HW-1:0] HB_S  = HW'(HB_START);
    localparam logic [HW-1:0] HB_E  = HW'(HB_END);
    localparam logic [HW-1:0] HS_S  = HW'(HS_START);
    localparam logic [HW-1:0] HS_E  = HW'(HS_END);
    localparam logic [HW-1:0] V_S   = HW'(V_START);
    localparam logic [HW-1:0] V_E   = HW'(V_END);
    localparam logic [HW-1:0] VB_S  = HW'(VB_START);
    localparam logic [HW-1:0] VB_E  = HW'(VB_END);
    localparam logic [HW-1:0] VS_S  = HW'(VS_START);
    localparam logic [HW-1:0] VS_E  = HW'(VS_END);
    // Mirror axis: a flipped line x maps to V_START+V_END-x.
    localparam logic [HW-1:0] V_SUM = HW'(V_START + V_END);

    localparam bit HB_EN = window_en(HB_START, HB_END);
    localparam bit HS_EN = window_en(HS_START, HS_END);
    localparam bit VB_EN = window_en(VB_START, VB_END);
    localparam bit VS_EN = window_en(VS_START, VS_END);

    function automatic logic [HW-1:0] v_inc(input logic [HW-1:0] x);
        return (x == V_E) ? V_S : x + 1'b1;
    endfunction

    function automatic logic [HW-1:0] v_mirror(input logic fl, input logic [HW-1:0] x);
        return fl ? V_SUM - x : x;
    endfunction

    logic          h_last;
    logic [HW-1:0] h_next;
    logic [HW-1:0] v_next;
    logic [HW-1:0] vr_next;
    logic [HW-1:0] vr1_next;
    logic [1:0]    dly_q;

    // Next-count values; the vertical count only moves on the last pixel.
    always_comb begin
        h_last   = (H == H_E);
        h_next   = h_last ? H_S : H + 1'b1;
        v_next   = h_last ? v_inc(vdump) : vdump;
        vr_next  = v_inc(v_next);
        vr1_next = v_inc(vr_next);
    end

    // Horizontal count, line/frame start strobes, horizontal blank and sync.
    always_ff @(posedge clk) begin
        if (rst) begin
            H     <= H_S;
            Hinit <= 1'b1;
            Vinit <= 1'b1;
            LHBL  <= 1'b0;
            HS    <= 1'b0;
        end else if (pxl_cen) begin
            H     <= h_next;
            Hinit <= (h_next == H_S);
            Vinit <= (h_next == H_S) && (v_next == V_S);
            if (HB_EN && H == HB_S)      LHBL <= 1'b0;
            else if (HB_EN && H == HB_E) LHBL <= 1'b1;
            if (HS_EN && H == HS_S)      HS <= 1'b1;
            else if (HS_EN && H == HS_E) HS <= 1'b0;
        end
    end

    // Vertical count, render lookahead (flip latched per line), vertical
    // blank/sync judged against the line being left, and frame parity.
    always_ff @(posedge clk) begin
        if (rst) begin
            vdump    <= V_S;
            vrender  <= v_inc(V_S);
            vrender1 <= v_inc(v_inc(V_S));
            LVBL     <= 1'b0;
            VS       <= 1'b0;
            frame    <= 1'b0;
        end else if (pxl_cen && h_last) begin
            vdump    <= v_next;
            vrender  <= v_mirror(flip, vr_next);
            vrender1 <= v_mirror(flip, vr1_next);
            if (vdump == V_E) frame <= ~frame;
            if (VB_EN && vdump == VB_S)      LVBL <= 1'b0;
            else if (VB_EN && vdump == VB_E) LVBL <= 1'b1;
            if (VS_EN && vdump == VS_S)      VS <= 1'b1;
            else if (VS_EN && vdump == VS_E) VS <= 1'b0;
        end
    end

    jtbubl_vtimer_dly #(
        .W   (2),
        .DLY (DLY)
    ) u_dly (
        .clk (clk),
        .rst (rst),
        .cen (pxl_cen),
        .d   ({LHBL, LVBL}),
        .q   (dly_q)
    );

    assign LHBL_dly = dly_q[1];
    assign LVBL_dly = dly_q[0];

endmodule

// File: tb/tb_jtbubl_vtimer_gen.sv
// Bench for jtbubl_vtimer_gen: dut_a uses the default raster, dut_b a
// 16-pixel line with the default vertical geometry so whole frames are cheap.
// Expected outputs come from a closed-form model indexed by the number of
// pixel enables since reset.
module tb_jtbubl_vtimer_gen;

  typedef struct packed {
    logic [8:0] h;
    logic [8:0] vdump;
    logic [8:0] vrender;
    logic [8:0] vrender1;
    logic hinit, vinit, lhbl, lvbl, lhbl_dly, lvbl_dly, hs, vs, frame;
  } obs_t;
  localparam int OBS_W = $bits(obs_t);

  typedef struct {
    int hs, he, hbs, hbe, hss, hse, vs, ve, vbs, vbe, vss, vse, dly;
  } geom_t;

  localparam int HL_A = 384;
  localparam int HL_B = 16;

  logic clk = 1'b0;
  logic rst, pxl_cen, flip;

  logic [8:0] h_a, vdump_a, vrender_a, vrender1_a;
  logic hinit_a, vinit_a, lhbl_a, lvbl_a, lhbl_dly_a, lvbl_dly_a, hs_a, vs_a, frame_a;
  logic [8:0] h_b, vdump_b, vrender_b, vrender1_b;
  logic hinit_b, vinit_b, lhbl_b, lvbl_b, lhbl_dly_b, lvbl_dly_b, hs_b, vs_b, frame_b;
  obs_t obs_a, obs_b;

  geom_t ga, gb;
  int n_a, n_b;
  bit fl_a, fl_b;
  logic [OBS_W-1:0] exp_qa[$];
  logic [OBS_W-1:0] exp_qb[$];
  int errors = 0;
  int checks = 0;

  // clock/reset block
  always #5 clk = ~clk;

  jtbubl_vtimer_gen dut_a (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip(flip),
    .H(h_a), .vdump(vdump_a), .vrender(vrender_a), .vrender1(vrender1_a),
    .Hinit(hinit_a), .Vinit(vinit_a), .LHBL(lhbl_a), .LVBL(lvbl_a),
    .LHBL_dly(lhbl_dly_a), .LVBL_dly(lvbl_dly_a), .HS(hs_a), .VS(vs_a), .frame(frame_a)
  );

  jtbubl_vtimer_gen #(
    .H_END(15), .HB_START(9), .HB_END(15), .HS_START(11), .HS_END(13), .DLY(2)
  ) dut_b (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .flip(flip),
    .H(h_b), .vdump(vdump_b), .vrender(vrender_b), .vrender1(vrender1_b),
    .Hinit(hinit_b), .Vinit(vinit_b), .LHBL(lhbl_b), .LVBL(lvbl_b),
    .LHBL_dly(lhbl_dly_b), .LVBL_dly(lvbl_dly_b), .HS(hs_b), .VS(vs_b), .frame(frame_b)
  );

  assign obs_a = {h_a, vdump_a, vrender_a, vrender1_a, hinit_a, vinit_a, lhbl_a, lvbl_a,
                  lhbl_dly_a, lvbl_dly_a, hs_a, vs_a, frame_a};
  assign obs_b = {h_b, vdump_b, vrender_b, vrender1_b, hinit_b, vinit_b, lhbl_b, lvbl_b,
                  lhbl_dly_b, lvbl_dly_b, hs_b, vs_b, frame_b};

  // ---------------- reference model ----------------
  // Blank is low inside (start,end]; outside it is high only once an end
  // event has happened since reset (first line / first frame stay low).
  function automatic bit lhbl_at(input geom_t g, input int n);
    int hl, h;
    hl = g.he - g.hs + 1;
    h  = g.hs + n % hl;
    if (h > g.hbs && h <= g.hbe) return 1'b0;
    return (n >= hl) || (h > g.hbe);
  endfunction

  function automatic bit lvbl_at(input geom_t g, input int n);
    int hl, vl, li, v;
    hl = g.he - g.hs + 1;
    vl = g.ve - g.vs + 1;
    li = n / hl;
    v  = g.vs + li % vl;
    if (v > g.vbs && v <= g.vbe) return 1'b0;
    return (li >= vl) || (v > g.vbe);
  endfunction

  function automatic int vinc(input geom_t g, input int x);
    return (x == g.ve) ? g.vs : x + 1;
  endfunction

  function automatic int mir(input geom_t g, input bit fl, input int x);
    return fl ? (g.vs + g.ve - x) : x;
  endfunction

  function automatic obs_t model(input geom_t g, input int n, input bit fl);
    obs_t e;
    int hl, vl, h, li, v, r1, r2;
    hl = g.he - g.hs + 1;
    vl = g.ve - g.vs + 1;
    h  = g.hs + n % hl;
    li = n / hl;
    v  = g.vs + li % vl;
    r1 = vinc(g, v);
    r2 = vinc(g, r1);
    e.h        = 9'(h);
    e.vdump    = 9'(v);
    e.vrender  = 9'(mir(g, fl, r1));
    e.vrender1 = 9'(mir(g, fl, r2));
    e.hinit    = (h == g.hs);
    e.vinit    = (h == g.hs) && (v == g.vs);
    e.lhbl     = lhbl_at(g, n);
    e.lvbl     = lvbl_at(g, n);
    e.lhbl_dly = (n >= g.dly) ? lhbl_at(g, n - g.dly) : 1'b0;
    e.lvbl_dly = (n >= g.dly) ? lvbl_at(g, n - g.dly) : 1'b0;
    e.hs       = (h > g.hss) && (h <= g.hse);
    e.vs       = (v > g.vss) && (v <= g.vse);
    e.frame    = ((li / vl) % 2) == 1;
    return e;
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge: applies inputs for the next posedge, advances the
  // model and queues the expected state, then returns at the next negedge.
  task automatic drive(input bit cen, input bit r);
    pxl_cen = cen;
    rst     = r;
    if (r) begin
      n_a = 0; n_b = 0; fl_a = 1'b0; fl_b = 1'b0;
    end else if (cen) begin
      if (n_a % HL_A == HL_A - 1) fl_a = flip;
      if (n_b % HL_B == HL_B - 1) fl_b = flip;
      n_a++;
      n_b++;
    end
    exp_qa.push_back(model(ga, n_a, fl_a));
    exp_qb.push_back(model(gb, n_b, fl_b));
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [OBS_W-1:0] ea, eb;
    for (int i = 0; i < 2; i++) begin
      drive(i[0], 1'b1);
      ea = exp_qa.pop_front(); eb = exp_qb.pop_front(); checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL reset dut_a got=%h exp=%h", obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL reset dut_b got=%h exp=%h", obs_b, eb); end
    end
    checks++;
    if ({h_a, vdump_a, vrender_a, vrender1_a} !== {9'd0, 9'd16, 9'd17, 9'd18}) begin
      errors++;
      $display("FAIL reset_counts got=%0d/%0d/%0d/%0d exp=0/16/17/18", h_a, vdump_a, vrender_a, vrender1_a);
    end
  endtask

  task automatic test_hline();
    logic [OBS_W-1:0] ea, eb;
    int hinit_cnt, hs_cnt, lhbl_lo, fall_n, dly_fall_n;
    logic prev_l, prev_d;
    hinit_cnt = 0; hs_cnt = 0; lhbl_lo = 0; fall_n = -1; dly_fall_n = -1;
    prev_l = lhbl_a; prev_d = lhbl_dly_a;
    for (int i = 0; i < 3 * HL_A; i++) begin
      drive(1'b1, 1'b0);
      ea = exp_qa.pop_front(); eb = exp_qb.pop_front(); checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL hline dut_a n=%0d got=%h exp=%h", n_a, obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL hline dut_b n=%0d got=%h exp=%h", n_b, obs_b, eb); end
      if (n_a <= HL_A && hinit_a) hinit_cnt++;
      if (n_a == HL_A) begin
        checks++;
        if (h_a !== 9'd0 || vdump_a !== 9'd17) begin
          errors++; $display("FAIL hline_wrap got H=%0d vdump=%0d exp H=0 vdump=17", h_a, vdump_a);
        end
      end
      if (n_a >= HL_A && n_a < 2 * HL_A) begin
        if (hs_a) hs_cnt++;
        if (!lhbl_a) lhbl_lo++;
      end
      if (prev_l && !lhbl_a && fall_n < 0) fall_n = n_a;
      if (prev_d && !lhbl_dly_a && dly_fall_n < 0) dly_fall_n = n_a;
      prev_l = lhbl_a; prev_d = lhbl_dly_a;
    end
    checks += 4;
    if (hinit_cnt != 1) begin errors++; $display("FAIL hinit_once got=%0d exp=1", hinit_cnt); end
    if (hs_cnt != 32) begin errors++; $display("FAIL hs_width got=%0d exp=32", hs_cnt); end
    if (lhbl_lo != 128) begin errors++; $display("FAIL lhbl_width got=%0d exp=128", lhbl_lo); end
    if (fall_n != 640 || dly_fall_n != 644) begin
      errors++; $display("FAIL lhbl_dly_lag got fall=%0d dly_fall=%0d exp 640/644", fall_n, dly_fall_n);
    end
  endtask

  task automatic test_stall();
    logic [OBS_W-1:0] ea, eb;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 1'b0);
      ea = exp_qa.pop_front(); eb = exp_qb.pop_front(); checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL stall dut_a n=%0d got=%h exp=%h", n_a, obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL stall dut_b n=%0d got=%h exp=%h", n_b, obs_b, eb); end
    end
  endtask

  task automatic test_frame();
    logic [OBS_W-1:0] ea, eb;
    int vs_lines, lvbl_lines, toggles, guard;
    bit seen_279;
    logic prev_f;
    vs_lines = 0; lvbl_lines = 0; toggles = 0; guard = 0; seen_279 = 1'b0;
    prev_f = frame_b;
    while (n_b < 8440 && guard < 20000) begin
      guard++;
      drive(1'b1, 1'b0);
      ea = exp_qa.pop_front(); eb = exp_qb.pop_front(); checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL frame dut_a n=%0d got=%h exp=%h", n_a, obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL frame dut_b n=%0d got=%h exp=%h", n_b, obs_b, eb); end
      if (hinit_b && vs_b && n_b < 4224) vs_lines++;
      if (hinit_b && !lvbl_b && n_b >= 4224) lvbl_lines++;
      if (frame_b !== prev_f) toggles++;
      prev_f = frame_b;
      if (hinit_b && vdump_b == 9'd279 && !seen_279) begin
        seen_279 = 1'b1;
        checks++;
        if (vrender_b !== 9'd16 || vrender1_b !== 9'd17) begin
          errors++; $display("FAIL vrender_wrap got=%0d/%0d exp=16/17", vrender_b, vrender1_b);
        end
      end
    end
    checks += 4;
    if (n_b < 8440 || !seen_279) begin errors++; $display("FAIL frame_timeout got n=%0d exp n=8440", n_b); end
    if (vs_lines != 8) begin errors++; $display("FAIL vs_lines got=%0d exp=8", vs_lines); end
    if (lvbl_lines != 40) begin errors++; $display("FAIL lvbl_lines got=%0d exp=40", lvbl_lines); end
    if (toggles != 1) begin errors++; $display("FAIL frame_toggle got=%0d exp=1", toggles); end
  endtask

  task automatic test_flip();
    logic [OBS_W-1:0] ea, eb;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      if (i == 3) flip = 1'b1;
      drive(1'b1, 1'b0);
      ea = exp_qa.pop_front(); eb = exp_qb.pop_front(); checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL flip dut_a n=%0d got=%h exp=%h", n_a, obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL flip dut_b n=%0d got=%h exp=%h", n_b, obs_b, eb); end
      if (hinit_b && vdump_b == 9'd100) found = 1'b1;
    end
    checks++;
    if (!found || vrender_b !== 9'd194 || vrender1_b !== 9'd193) begin
      errors++; $display("FAIL flip_100 got found=%0d vrender=%0d/%0d exp 1 194/193", found, vrender_b, vrender1_b);
    end
  endtask

  task automatic test_reset_mid();
    logic [OBS_W-1:0] ea, eb;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 4000 && !found; i++) begin
      drive(1'b1, 1'b0);
      ea = exp_qa.pop_front(); eb = exp_qb.pop_front(); checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL run dut_a n=%0d got=%h exp=%h", n_a, obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL run dut_b n=%0d got=%h exp=%h", n_b, obs_b, eb); end
      if (vdump_b == 9'd200 && h_b == 9'd10) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL reset_mid_reach got vdump=%0d H=%0d exp 200/10", vdump_b, h_b); end
    for (int i = 0; i < 8; i++) begin
      drive(i != 0, i == 0);
      ea = exp_qa.pop_front(); eb = exp_qb.pop_front(); checks += 2;
      if (obs_a !== ea) begin errors++; $display("FAIL reset_mid dut_a n=%0d got=%h exp=%h", n_a, obs_a, ea); end
      if (obs_b !== eb) begin errors++; $display("FAIL reset_mid dut_b n=%0d got=%h exp=%h", n_b, obs_b, eb); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    ga = '{0, 383, 255, 383, 287, 319, 16, 279, 239, 279, 255, 263, 4};
    gb = '{0, 15, 9, 15, 11, 13, 16, 279, 239, 279, 255, 263, 2};
    n_a = 0; n_b = 0; fl_a = 1'b0; fl_b = 1'b0;
    rst = 1'b1; pxl_cen = 1'b0; flip = 1'b0;
    @(negedge clk);
    test_reset();
    test_hline();
    test_stall();
    test_frame();
    test_flip();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
